// File: rtl/equalizer_sequencer.sv
// Phase controller for the histogram-equalization pipeline: clears M2, then runs
// the histogram, CDF and output-mapping units in turn and owns the M2 write port.
module equalizer_sequencer #(
  parameter int unsigned PIXEL_COUNT = 64,
  parameter int unsigned CLEAR_WORDS = 64,
  parameter logic [19:0] TIMEOUT     = 20'hFFFFF
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic          hist_start_o,
  input  logic          hist_done_i,
  output logic          cdf_start_o,
  input  logic          cdf_done_i,
  input  logic          cdf_min_valid_i,
  input  logic [19:0]   cdf_min_in_i,
  output logic          out_start_o,
  input  logic          out_done_i,
  output logic [19:0]   CdfMin_o,
  output logic [19:0]   divisor_o,
  input  logic          hist_we_i,
  input  logic [15:0]   hist_waddr_i,
  input  logic [127:0]  hist_wbus_i,
  input  logic          cdf_we_i,
  input  logic [15:0]   cdf_waddr_i,
  input  logic [127:0]  cdf_wbus_i,
  output logic          m2_WriteEnable_o,
  output logic [15:0]   m2_WriteAddress_o,
  output logic [127:0]  m2_WriteBus_o
);

  // state | meaning
  // IDLE  | wait for start          CLEAR | zero-fill histogram words
  // HIST  | histogram unit running  CDF   | CDF unit running, capture minimum
  // MAP   | output mapping running  DONE  | one-cycle completion
  // ERR   | fault, held until abort or reset
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_HIST, S_CDF, S_MAP, S_DONE, S_ERR
  } state_e;

  localparam logic [19:0] PIX_CNT  = 20'(PIXEL_COUNT);
  localparam logic [15:0] CLR_LAST = 16'(CLEAR_WORDS - 1);
  localparam logic [19:0] TO_LAST  = TIMEOUT - 20'd1;

  state_e        state_q, state_d;
  logic [15:0]   clr_cnt_q, clr_cnt_d;
  logic [19:0]   phase_cnt_q, phase_cnt_d;
  logic          min_cap_q, min_cap_d;
  logic [19:0]   cdf_min_q, cdf_min_d;
  logic [19:0]   divisor_q, divisor_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          hist_start_q, hist_start_d;
  logic          cdf_start_q, cdf_start_d;
  logic          out_start_q, out_start_d;
  logic          min_seen;
  logic [19:0]   min_val;
  logic          timed_out;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      clr_cnt_q    <= '0;
      phase_cnt_q  <= '0;
      min_cap_q    <= 1'b0;
      cdf_min_q    <= '0;
      divisor_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      hist_start_q <= 1'b0;
      cdf_start_q  <= 1'b0;
      out_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      phase_cnt_q  <= phase_cnt_d;
      min_cap_q    <= min_cap_d;
      cdf_min_q    <= cdf_min_d;
      divisor_q    <= divisor_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      hist_start_q <= hist_start_d;
      cdf_start_q  <= cdf_start_d;
      out_start_q  <= out_start_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = '0;
    phase_cnt_d = '0;
    min_cap_d   = min_cap_q;
    cdf_min_d   = cdf_min_q;
    divisor_d   = divisor_q;
    // a minimum arriving with cdf_done still counts for that decision
    min_seen    = min_cap_q | cdf_min_valid_i;
    min_val     = min_cap_q ? cdf_min_q : cdf_min_in_i;
    timed_out   = (phase_cnt_q == TO_LAST);
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_i) state_d = S_CLEAR;
        S_CLEAR: begin
          if (clr_cnt_q == CLR_LAST) state_d = S_HIST;
          else                       clr_cnt_d = clr_cnt_q + 16'd1;
        end
        S_HIST: begin
          if (hist_done_i)    state_d = S_CDF;
          else if (timed_out) state_d = S_ERR;
          else                phase_cnt_d = phase_cnt_q + 20'd1;
        end
        S_CDF: begin
          if (cdf_min_valid_i && !min_cap_q) begin
            cdf_min_d = cdf_min_in_i;
            min_cap_d = 1'b1;
          end
          if (cdf_done_i) begin
            if (!min_seen || (min_val >= PIX_CNT)) begin
              state_d = S_ERR;
            end else begin
              divisor_d = PIX_CNT - min_val;
              state_d   = S_MAP;
            end
          end else if (timed_out) begin
            state_d = S_ERR;
          end else begin
            phase_cnt_d = phase_cnt_q + 20'd1;
          end
        end
        S_MAP: begin
          if (out_done_i)     state_d = S_DONE;
          else if (timed_out) state_d = S_ERR;
          else                phase_cnt_d = phase_cnt_q + 20'd1;
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
    if (state_d == S_IDLE) min_cap_d = 1'b0;
  end

  always_comb begin
    hist_start_d = (state_d == S_HIST) && (state_q != S_HIST);
    cdf_start_d  = (state_d == S_CDF)  && (state_q != S_CDF);
    out_start_d  = (state_d == S_MAP)  && (state_q != S_MAP);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    busy_d       = state_d inside {S_CLEAR, S_HIST, S_CDF, S_MAP};
    m2_WriteEnable_o  = 1'b0;
    m2_WriteAddress_o = '0;
    m2_WriteBus_o     = '0;
    case (state_q)
      S_CLEAR: begin
        m2_WriteEnable_o  = 1'b1;
        m2_WriteAddress_o = clr_cnt_q;
      end
      S_HIST: begin
        m2_WriteEnable_o  = hist_we_i;
        m2_WriteAddress_o = hist_waddr_i;
        m2_WriteBus_o     = hist_wbus_i;
      end
      S_CDF: begin
        m2_WriteEnable_o  = cdf_we_i;
        m2_WriteAddress_o = cdf_waddr_i;
        m2_WriteBus_o     = cdf_wbus_i;
      end
      default: ;
    endcase
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign hist_start_o = hist_start_q;
  assign cdf_start_o  = cdf_start_q;
  assign out_start_o  = out_start_q;
  assign CdfMin_o     = cdf_min_q;
  assign divisor_o    = divisor_q;

endmodule
